udp_audio_depack: RTL and testbench

Receive-side audio path: takes the byte stream delivered by the UDP receive interface of the Ethernet core and unpacks it into 16-bit PCM samples. It buffers the samples in a jitter FIFO and supplies them to the WM8731 playback port (`wav_out_data`) one sample per `wav_rden` request. It mirrors the transmit path that packs captured samples from `wav_in_data`/`wav_wren` into UDP payloads.

---
 rtl/udp_audio_depack.sv | 137 +++++++++++++
 tb/tb_udp_audio_depack.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_audio_depack.sv
// UDP receive payload to 16-bit PCM playback path.
// Bytes pair up little-endian into a jitter FIFO that feeds a prefill-gated playback port.
module udp_audio_depack #(
    parameter int unsigned FIFO_AW     = 10,
    parameter int unsigned PREFILL     = 256,
    parameter int unsigned UDP_HDR_LEN = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               udp_rec_data_valid,
    input  logic [7:0]         udp_rec_rdata,
    input  logic [15:0]        udp_rec_data_length,
    input  logic               wav_rden,
    output logic [15:0]        wav_out_data,
    output logic               playing,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [15:0]        underrun_cnt,
    output logic [15:0]        overflow_cnt
);
    localparam int unsigned        Depth      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FullLvl    = (FIFO_AW + 1)'(Depth);
    localparam logic [FIFO_AW:0]   PrefillLvl = (FIFO_AW + 1)'(PREFILL);
    localparam logic [FIFO_AW:0]   LvlOne     = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PtrOne     = FIFO_AW'(1);
    localparam logic [15:0]        HdrLen     = 16'(UDP_HDR_LEN);

    typedef enum logic {StBuffer, StPlay} state_e;

    state_e              state_q, state_d;
    logic                in_pkt_q;
    logic [15:0]         plen_q, bcnt_q;
    logic [7:0]          lo_q;
    logic [15:0]         new_plen, cur_plen, cur_idx;
    logic                accept, last_byte, wr_req;
    logic [15:0]         wr_data;
    logic [15:0]         mem [Depth];
    logic [FIFO_AW-1:0]  wptr_q, rptr_q;
    logic [FIFO_AW:0]    level_q, level_d;
    logic                empty, full, rd_en, wr_en, ovf_evt, und_evt;

    // Outside a packet the current byte is index 0 of a packet framed by this cycle's length.
    always_comb begin
        new_plen  = (udp_rec_data_length < HdrLen) ? 16'd0 : udp_rec_data_length - HdrLen;
        cur_plen  = in_pkt_q ? plen_q : new_plen;
        cur_idx   = in_pkt_q ? bcnt_q : 16'd0;
        accept    = udp_rec_data_valid && (cur_plen != 16'd0);
        last_byte = (cur_idx + 16'd1) == cur_plen;
        wr_req    = accept && cur_idx[0];
        wr_data   = {udp_rec_rdata, lo_q};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_pkt_q <= 1'b0;
            plen_q   <= 16'd0;
            bcnt_q   <= 16'd0;
            lo_q     <= 8'd0;
        end else if (accept) begin
            plen_q <= cur_plen;
            if (!cur_idx[0]) begin
                lo_q <= udp_rec_rdata;
            end
            if (last_byte) begin
                in_pkt_q <= 1'b0;
                bcnt_q   <= 16'd0;
            end else begin
                in_pkt_q <= 1'b1;
                bcnt_q   <= cur_idx + 16'd1;
            end
        end
    end

    // A read in the same cycle frees the slot, so a write at full is still accepted.
    always_comb begin
        empty   = level_q == '0;
        full    = level_q == FullLvl;
        rd_en   = (state_q == StPlay) && wav_rden && !empty;
        und_evt = (state_q == StPlay) && wav_rden && empty;
        wr_en   = wr_req && (!full || rd_en);
        ovf_evt = wr_req && !wr_en;
        level_d = level_q;
        unique case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LvlOne;
            2'b01:   level_d = level_q - LvlOne;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            wav_out_data <= 16'd0;
            underrun_cnt <= 16'd0;
            overflow_cnt <= 16'd0;
            state_q      <= StBuffer;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            if (wr_en) begin
                wptr_q <= wptr_q + PtrOne;
            end
            if (rd_en) begin
                rptr_q       <= rptr_q + PtrOne;
                wav_out_data <= mem[rptr_q];
            end else if (wav_rden) begin
                wav_out_data <= 16'd0;
            end
            if (und_evt && underrun_cnt != 16'hFFFF) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
            if (ovf_evt && overflow_cnt != 16'hFFFF) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBuffer: if (level_q >= PrefillLvl) state_d = StPlay;
            StPlay:   if (und_evt) state_d = StBuffer;
            default:  state_d = StBuffer;
        endcase
    end

    assign playing    = state_q == StPlay;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_udp_audio_depack.sv
// Random and directed stimulus for udp_audio_depack, checked every cycle against a
// packet/queue level model of the receive path.
module tb_udp_audio_depack;
    localparam int AW = 10, PREFILL = 256, HDR = 8, DEPTH = 1024;

    logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, rden = 1'b0;
    logic [7:0]  rdata = 8'd0;
    logic [15:0] len = 16'd0;
    logic [15:0] wav_out_data, underrun_cnt, overflow_cnt;
    logic        playing;
    logic [AW:0] fifo_level;

    udp_audio_depack #(.FIFO_AW(AW), .PREFILL(PREFILL), .UDP_HDR_LEN(HDR)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .udp_rec_data_valid  (valid),
        .udp_rec_rdata       (rdata),
        .udp_rec_data_length (len),
        .wav_rden            (rden),
        .wav_out_data        (wav_out_data),
        .playing             (playing),
        .fifo_level          (fifo_level),
        .underrun_cnt        (underrun_cnt),
        .overflow_cnt        (overflow_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int rd_pct = 0;
    bit started = 0;

    // Model state: the expected FIFO contents as a plain queue.
    int m_q[$];
    bit m_play;
    int m_out, m_under, m_over;
    bit exp_wr = 0;
    int exp_sample = 0;
    logic [7:0] pkt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int  old_size;
        bit  old_play, popped;
        if (!rst_n) begin
            m_q.delete();
            m_play  = 0;
            m_out   = 0;
            m_under = 0;
            m_over  = 0;
        end else begin
            old_size = m_q.size();
            old_play = m_play;
            popped   = 0;
            if (rden) begin
                if (old_play && old_size > 0) begin
                    m_out  = m_q.pop_front();
                    popped = 1;
                end else begin
                    m_out = 0;
                    if (old_play) begin
                        m_play = 0;
                        if (m_under < 65535) m_under++;
                    end
                end
            end
            if (exp_wr) begin
                if (old_size < DEPTH || popped) m_q.push_back(exp_sample);
                else if (m_over < 65535) m_over++;
            end
            if (!old_play && old_size >= PREFILL) m_play = 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out_data", wav_out_data, m_out);
            chk("playing", playing, m_play);
            chk("fifo_level", fifo_level, m_q.size());
            chk("underrun_cnt", underrun_cnt, m_under);
            chk("overflow_cnt", overflow_cnt, m_over);
        end
    end

    task automatic step(input bit v, input logic [7:0] d, input logic [15:0] l,
                        input bit w, input int ws, input bit r);
        bit r_eff;
        r_eff = r || (rd_pct > 0 && !rden && $urandom_range(99) < rd_pct);
        @(posedge clk);
        #1;
        valid = v; rdata = d; len = l; exp_wr = w; exp_sample = ws; rden = r_eff;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 8'($urandom), 16'($urandom), 0, 0, 0);
    endtask

    task automatic rd_pulse();
        step(0, 8'd0, 16'd0, 0, 0, 1);
        step(0, 8'd0, 16'd0, 0, 0, 0);
    endtask

    // Sends the first nsend bytes of pkt; only the first byte carries the real length.
    task automatic send_pkt(input int lenf, input int gap_pct, input int nsend);
        for (int i = 0; i < nsend; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) idle(1);
            step(1, pkt[i], (i == 0) ? 16'(lenf) : 16'($urandom), (i % 2) == 1,
                 (i % 2) == 1 ? int'({pkt[i], pkt[i-1]}) : 0, 0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 0; valid = 0; rden = 0; exp_wr = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic wait_playing(input int bound);
        int i = 0;
        while (!playing && i < bound) begin
            idle(1);
            i++;
        end
        chk("prefill_wait", playing, 1);
    endtask

    initial begin
        int plen;
        idle(2);
        started = 1;
        rst_n = 1;
        idle(1);
        chk("rst_out", wav_out_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_playing", playing, 0);

        // Basic playback.
        pkt.delete();
        for (int k = 0; k < 512; k++) pkt.push_back(8'(k));
        send_pkt(520, 0, 512);
        wait_playing(10);
        chk("basic_level", fifo_level, 256);
        rd_pulse();
        chk("basic_s0", wav_out_data, 16'h0100);
        rd_pulse();
        chk("basic_s1", wav_out_data, 16'h0302);

        // Underrun.
        do_reset();
        pkt.delete();
        for (int k = 0; k < 512; k++) pkt.push_back(8'($urandom));
        send_pkt(520, 10, 512);
        wait_playing(10);
        repeat (257) rd_pulse();
        chk("und_out", wav_out_data, 0);
        chk("und_cnt", underrun_cnt, 1);
        chk("und_playing", playing, 0);
        repeat (3) rd_pulse();
        chk("und_cnt_hold", underrun_cnt, 1);

        // Odd payload, then top up to prefill and read back.
        do_reset();
        pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_pkt(13, 0, 5);
        pkt = '{8'hAA, 8'hBB};
        send_pkt(10, 30, 2);
        idle(2);
        chk("odd_level", fifo_level, 3);
        chk("model_odd0", m_q[0], 32'h2211);
        chk("model_odd2", m_q[2], 32'hBBAA);
        pkt.delete();
        for (int k = 0; k < 506; k++) pkt.push_back(8'd0);
        send_pkt(514, 0, 506);
        wait_playing(10);
        rd_pulse();
        chk("odd_s0", wav_out_data, 16'h2211);
        rd_pulse();
        chk("odd_s1", wav_out_data, 16'h4433);
        rd_pulse();
        chk("odd_s2", wav_out_data, 16'hBBAA);

        // Overflow, then read+write at full.
        do_reset();
        pkt.delete();
        for (int k = 0; k < 1030; k++) begin
            pkt.push_back(8'(k));
            pkt.push_back(8'(k >> 8));
        end
        send_pkt(8 + 2060, 0, 2060);
        idle(2);
        chk("ovf_level", fifo_level, 1024);
        chk("ovf_cnt", overflow_cnt, 6);
        step(1, 8'h77, 16'd10, 0, 0, 0);
        step(1, 8'h66, 16'($urandom), 1, 32'h6677, 1);
        idle(1);
        chk("rw_full_level", fifo_level, 1024);
        chk("rw_full_ovf", overflow_cnt, 6);
        chk("rw_full_out", wav_out_data, 0);
        for (int k = 1; k <= 4; k++) begin
            rd_pulse();
            chk("ovf_order", wav_out_data, k);
        end

        // Random traffic: write-heavy, then read-heavy.
        do_reset();
        for (int phase = 0; phase < 2; phase++) begin
            rd_pct = (phase == 0) ? 15 : 45;
            for (int p = 0; p < ((phase == 0) ? 200 : 80); p++) begin
                plen = $urandom_range(40, 1);
                pkt.delete();
                for (int k = 0; k < plen; k++) pkt.push_back(8'($urandom));
                send_pkt(plen + HDR, (phase == 0) ? 25 : 70, plen);
            end
        end
        rd_pct = 0;
        idle(2);

        // Mid-packet reset.
        do_reset();
        pkt.delete();
        for (int k = 0; k < 100; k++) pkt.push_back(8'($urandom));
        send_pkt(108, 0, 3);
        do_reset();
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_out", wav_out_data, 0);
        pkt = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_pkt(12, 0, 4);
        idle(2);
        chk("mid_fresh_level", fifo_level, 2);
        chk("mid_fresh_playing", playing, 0);
        chk("mid_fresh_ovf", overflow_cnt, 0);
        chk("mid_fresh_und", underrun_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
